// File: rtl/hram_arb.sv
// hram_arb: two-port arbiter sharing one octal PSRAM controller port.
// Registers the winning request, sequences the handshake, watchdogs hangs.
module hram_arb #(
    parameter int          ROUND_ROBIN    = 1,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic [31:0] p0_rdata,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic [31:0] p1_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        grant,
    output logic        busy,
    output logic        fault
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] ERRACK = 2'd3;

    logic [1:0]      state;
    logic [WD_W-1:0] wd;
    logic            pick;
    logic            wd_expired;
    logic            done;
    logic [31:0]     done_data;

    assign busy       = (state != IDLE);
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);

    // Choose the port to serve: lone requester wins, contention by policy
    always_comb begin
        pick = 1'b0;
        if (p0_valid && p1_valid)
            pick = (ROUND_ROBIN != 0) ? !grant : 1'b0;
        else if (p1_valid)
            pick = 1'b1;
    end

    // Completion this cycle and the data returned to the granted port
    always_comb begin
        done      = 1'b0;
        done_data = ERR_DATA;
        if (state == REQ) begin
            done = mem_ready || wd_expired;
            if (mem_ready)
                done_data = mem_rdata;
        end else if (state == ERRACK) begin
            done = 1'b1;
        end
    end

    // Arbiter FSM, payload register, watchdog and requester responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            p0_ready  <= 1'b0;
            p1_ready  <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            grant     <= 1'b1;
            fault     <= 1'b0;
            wd        <= '0;
        end else begin
            p0_ready <= 1'b0;
            p1_ready <= 1'b0;
            if (done) begin
                if (grant) begin
                    p1_ready <= 1'b1;
                    p1_rdata <= done_data;
                end else begin
                    p0_ready <= 1'b1;
                    p0_rdata <= done_data;
                end
            end
            case (state)
                IDLE: begin
                    if (p0_valid || p1_valid) begin
                        grant     <= pick;
                        mem_addr  <= pick ? p1_addr  : p0_addr;
                        mem_wdata <= pick ? p1_wdata : p0_wdata;
                        mem_wstrb <= pick ? p1_wstrb : p0_wstrb;
                        if (fault) begin
                            state <= ERRACK;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        wd        <= '0;
                        state     <= DRAIN;
                    end else if (wd_expired) begin
                        fault     <= 1'b1;
                        mem_valid <= 1'b0;
                        wd        <= '0;
                        state     <= DRAIN;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!mem_ready)
                        state <= IDLE;
                end
                ERRACK: begin
                    state <= DRAIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hram_arb.sv
// tb_hram_arb: directed vector bench for hram_arb.
// Round-robin instance with a 16-cycle watchdog plus a fixed-priority one.
module tb_hram_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p0_wstrb = '0, p1_wstrb = '0;
    logic        p0_ready, p1_ready;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        grant, busy, fault;

    logic        f0_valid = 1'b0, f1_valid = 1'b0;
    logic        f0_ready, f1_ready;
    logic [31:0] f0_rdata, f1_rdata;
    logic        fmem_valid;
    logic        fmem_ready = 1'b0;
    logic [31:0] fmem_addr, fmem_wdata;
    logic [3:0]  fmem_wstrb;
    logic [31:0] fmem_rdata = '0;
    logic        f_grant, f_busy, f_fault;

    int          m_lat = 1;
    bit          m_hang = 1'b0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;
    int          fm_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        bit          hang;
        logic [31:0] mdata;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        bit          exp_memv;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    hram_arb #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(16)) u_rr (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_rdata(p1_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy), .fault(fault)
    );

    hram_arb #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(16)) u_fp (
        .clk(clk), .reset(reset),
        .p0_valid(f0_valid), .p0_ready(f0_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_rdata(f0_rdata),
        .p1_valid(f1_valid), .p1_ready(f1_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_rdata(f1_rdata),
        .mem_valid(fmem_valid), .mem_ready(fmem_ready), .mem_addr(fmem_addr),
        .mem_wdata(fmem_wdata), .mem_wstrb(fmem_wstrb), .mem_rdata(fmem_rdata),
        .grant(f_grant), .busy(f_busy), .fault(f_fault)
    );

    // Controller model: ready m_lat cycles after valid, held until valid drops
    always @(posedge clk) begin
        if (!mem_valid) begin
            mem_ready <= 1'b0;
            m_cnt     <= 0;
        end else if (!mem_ready && !m_hang) begin
            if (m_cnt >= m_lat - 1) begin
                mem_ready <= 1'b1;
                mem_rdata <= m_data;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Controller model for the fixed-priority instance, latency 2
    always @(posedge clk) begin
        if (!fmem_valid) begin
            fmem_ready <= 1'b0;
            fm_cnt     <= 0;
        end else if (!fmem_ready) begin
            if (fm_cnt >= 1) begin
                fmem_ready <= 1'b1;
                fmem_rdata <= 32'h0000_F00D;
            end else begin
                fm_cnt <= fm_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 32 && (busy || f_busy); c++)
            tick();
        chk(nm, {30'd0, busy, f_busy}, 32'd0);
    endtask

    task automatic do_reset();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        f0_valid = 1'b0;
        f1_valid = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] other_rd;
        int          n;
        bit          seen, other_rdy, memv_seen, pay_ok;
        m_lat  = v.lat;
        m_hang = v.hang;
        m_data = v.mdata;
        tick();
        if (v.port) begin
            p1_valid = 1'b1; p1_addr = v.addr;
            p1_wdata = v.wdata; p1_wstrb = v.wstrb;
        end else begin
            p0_valid = 1'b1; p0_addr = v.addr;
            p0_wdata = v.wdata; p0_wstrb = v.wstrb;
        end
        other_rd = v.port ? p0_rdata : p1_rdata;
        chk({v.name, "_mv_before"}, mem_valid, 0);
        tick();
        chk({v.name, "_mem_valid"}, mem_valid, v.exp_memv);
        chk({v.name, "_addr"}, mem_addr, v.addr);
        chk({v.name, "_wdata"}, mem_wdata, v.wdata);
        chk({v.name, "_wstrb"}, mem_wstrb, v.wstrb);
        chk({v.name, "_grant"}, grant, v.port);
        chk({v.name, "_busy"}, busy, 1);
        n = 0; seen = 0; other_rdy = 0; memv_seen = mem_valid; pay_ok = 1;
        while (!seen && n < 64) begin
            tick();
            n++;
            seen = v.port ? p1_ready : p0_ready;
            other_rdy |= v.port ? p0_ready : p1_ready;
            memv_seen |= mem_valid;
            if (mem_addr !== v.addr || mem_wdata !== v.wdata ||
                mem_wstrb !== v.wstrb)
                pay_ok = 0;
        end
        chk({v.name, "_ready_seen"}, seen, 1);
        chk({v.name, "_latency"}, n, v.exp_cyc);
        chk({v.name, "_rdata"}, v.port ? p1_rdata : p0_rdata, v.exp_rdata);
        chk({v.name, "_fault"}, fault, v.exp_fault);
        chk({v.name, "_other_ready"}, other_rdy, 0);
        chk({v.name, "_other_rdata"}, v.port ? p0_rdata : p1_rdata, other_rd);
        chk({v.name, "_memv_seen"}, memv_seen, v.exp_memv);
        chk({v.name, "_payload_stable"}, pay_ok, 1);
        tick();
        chk({v.name, "_pulse_width"}, v.port ? p1_ready : p0_ready, 0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        wait_idle({v.name, "_idle"});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang, want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit   seen, mv_prev;
        vec_t fresh;

        vecs[0] = '{"rd0",  1'b0, 32'h0000_0100, 32'h0, 4'h0, 10, 1'b0,
                    32'h1234_5678, 32'h1234_5678, 11, 1'b1, 1'b0};
        vecs[1] = '{"wr1",  1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 4'b0101, 3, 1'b0,
                    32'h0BAD_F00D, 32'h0BAD_F00D, 4, 1'b1, 1'b0};
        vecs[2] = '{"rd1",  1'b1, 32'h0000_0008, 32'h0, 4'h0, 1, 1'b0,
                    32'hCAFE_BABE, 32'hCAFE_BABE, 2, 1'b1, 1'b0};
        vecs[3] = '{"rd0b", 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 5, 1'b0,
                    32'h0000_0000, 32'h0000_0000, 6, 1'b1, 1'b0};
        vecs[4] = '{"wdog", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 1'b1,
                    32'h1111_1111, 32'hFFFF_FFFF, 16, 1'b1, 1'b1};
        vecs[5] = '{"err1", 1'b1, 32'h0000_0300, 32'h1, 4'hF, 1, 1'b0,
                    32'h2222_2222, 32'hFFFF_FFFF, 1, 1'b0, 1'b1};
        vecs[6] = '{"err0", 1'b0, 32'h0000_0304, 32'h0, 4'h0, 1, 1'b0,
                    32'h3333_3333, 32'hFFFF_FFFF, 1, 1'b0, 1'b1};

        do_reset();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ready", {p0_ready, p1_ready}, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_grant", grant, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // reset clears a sticky fault, then reset in the middle of REQ
        do_reset();
        chk("clr_fault", fault, 0);
        m_lat = 20; m_hang = 1'b0;
        p0_valid = 1'b1; p0_addr = 32'h0000_0500;
        tick();
        chk("mid_req_valid", mem_valid, 1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        p0_valid = 1'b0;
        chk("mid_rst_mem_valid", mem_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_grant", grant, 1);
        chk("mid_rst_p0_ready", p0_ready, 0);
        tick();
        fresh = '{"fresh1", 1'b1, 32'h0000_0044, 32'h0, 4'h0, 4, 1'b0,
                  32'h600D_CAFE, 32'h600D_CAFE, 5, 1'b1, 1'b0};
        run_vec(fresh);

        // round-robin contention: both requesters re-request at once
        do_reset();
        m_lat = 3; m_hang = 1'b0;
        p0_addr = 32'h10; p0_wstrb = 4'h0;
        p1_addr = 32'h20; p1_wstrb = 4'h0;
        p0_valid = 1'b1; p1_valid = 1'b1;
        mv_prev = 1'b0;
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                if (mem_valid && !mv_prev)
                    chk("rr_no_overlap", mem_ready, 0);
                mv_prev = mem_valid;
                seen = p0_ready | p1_ready;
            end
            chk("rr_seen", seen, 1);
            chk($sformatf("rr_order%0d", t), p1_ready, t % 2);
            chk("rr_one_hot", p0_ready & p1_ready, 0);
            chk("rr_grant", grant, t % 2);
            tick();
            mv_prev = mem_valid;
            if (t % 2 == 1) p1_valid = 1'b0;
            else p0_valid = 1'b0;
            tick();
            mv_prev = mem_valid;
            p0_valid = 1'b1;
            p1_valid = 1'b1;
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        wait_idle("rr_idle");

        // fixed priority: port 0 starves port 1 until it stops asking
        do_reset();
        f0_valid = 1'b1;
        f1_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                seen = f0_ready | f1_ready;
            end
            chk("fp_seen", seen, 1);
            chk($sformatf("fp_port%0d", t), f1_ready, (t == 3));
            chk("fp_grant", f_grant, (t == 3));
            chk("fp_rdata", f1_ready ? f1_rdata : f0_rdata, 32'h0000_F00D);
            tick();
            if (t == 3) f1_valid = 1'b0;
            else f0_valid = 1'b0;
            tick();
            if (t < 2) f0_valid = 1'b1;
        end
        wait_idle("fp_idle");
        chk("fp_fault", f_fault, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
